// File: rtl/sdram_pkg.sv
// sdram_pkg: definitions shared by the SDRAM controller blocks.
// Contents:
//   - default DQ and address widths
//   - SDRAM command encodings, packed as {cs_n, ras_n, cas_n, we_n}
//   - the command arbiter's state encoding
package sdram_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 13;

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_PREC  = 4'b0010;
  localparam logic [3:0] CMD_AREF  = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_BSTOP = 4'b0110;

  typedef enum logic [2:0] {
    ARB_INIT  = 3'd0,
    ARB_IDLE  = 3'd1,
    ARB_AREF  = 3'd2,
    ARB_WRITE = 3'd3,
    ARB_READ  = 3'd4
  } arb_state_e;

endpackage

// File: rtl/sdram_arb_sel.sv
// sdram_arb_sel: request selector used while the arbiter is idle.
// Refresh always wins. When write and read are both pending, prefer_rd
// picks read; otherwise write wins.
// Ports:
//   aref_req, wr_req, rd_req  in   level requests
//   prefer_rd                 in   1 = read wins a write/read tie
//   sel                       out  state to enter (ARB_IDLE if nothing pending)
module sdram_arb_sel
  import sdram_pkg::*;
(
  input  logic       aref_req,
  input  logic       wr_req,
  input  logic       rd_req,
  input  logic       prefer_rd,
  output arb_state_e sel
);

  always_comb begin
    sel = ARB_IDLE;
    if (aref_req) begin
      sel = ARB_AREF;
    end else if (wr_req && rd_req) begin
      sel = prefer_rd ? ARB_READ : ARB_WRITE;
    end else if (wr_req) begin
      sel = ARB_WRITE;
    end else if (rd_req) begin
      sel = ARB_READ;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: command arbiter and pin multiplexer in front of the SDRAM.
// It passes the init sequence through until init_end. After that it grants
// one of refresh, write or read at a time, and drives the granted source's
// command, bank, address and data onto the SDRAM pins.
// Optional feature: define SDRAM_ARB_ROUND_ROBIN_EN to alternate write and
// read when both are pending. Without it, write has fixed priority over read.
// Ports:
//   clk, rstn                         clock, async active-low reset
//   init_* / aref_* / wr_* / rd_*     per-source command, bank, address
//   init_end                          init complete (level, used only in ARB_INIT)
//   *_req / *_end                     level request / done pulse per source
//   aref_en, wr_en, rd_en             grants, decoded from the state register
//   wr_data, wr_sdram_en              write data and its bus-valid strobe
//   sdram_*                           device pins; DQ is split into out/oe
//   arb_state                         current arbiter state (debug)
// Handshake: a source holds *_req high until its grant rises. The grant then
// stays high until the source pulses *_end. An *_end from a source that
// does not hold the grant is ignored.
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [3:0]        init_cmd,
  input  logic [1:0]        init_bank,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic              init_end,
  input  logic              aref_req,
  input  logic              aref_end,
  input  logic [3:0]        aref_cmd,
  input  logic [1:0]        aref_bank,
  input  logic [ADDR_W-1:0] aref_addr,
  output logic              aref_en,
  input  logic              wr_req,
  input  logic              wr_end,
  input  logic [3:0]        wr_cmd,
  input  logic [1:0]        wr_bank,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_sdram_en,
  output logic              wr_en,
  input  logic              rd_req,
  input  logic              rd_end,
  input  logic [3:0]        rd_cmd,
  input  logic [1:0]        rd_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic              sdram_cke,
  output logic              sdram_cs_n,
  output logic              sdram_ras_n,
  output logic              sdram_cas_n,
  output logic              sdram_we_n,
  output logic [1:0]        sdram_ba,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [DATA_W-1:0] sdram_dq_out,
  output logic              sdram_dq_oe,
  output arb_state_e        arb_state
);

  arb_state_e        state, next_state, sel;
  logic              prefer_rd;
  logic [3:0]        cmd;

  sdram_arb_sel u_sel (
    .aref_req  (aref_req),
    .wr_req    (wr_req),
    .rd_req    (rd_req),
    .prefer_rd (prefer_rd),
    .sel       (sel)
  );

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Remembers whether the last write/read grant went to write. It resets to
  // "read", so the first tie after reset goes to write.
  logic last_wr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_wr <= 1'b0;
    end else if (state == ARB_IDLE && next_state == ARB_WRITE) begin
      last_wr <= 1'b1;
    end else if (state == ARB_IDLE && next_state == ARB_READ) begin
      last_wr <= 1'b0;
    end
  end

  assign prefer_rd = last_wr;
`else
  assign prefer_rd = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ARB_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Each busy state watches only its own *_end, so stray pulses are ignored.
  always_comb begin
    next_state = state;
    unique case (state)
      ARB_INIT:  if (init_end) next_state = ARB_IDLE;
      ARB_IDLE:  next_state = sel;
      ARB_AREF:  if (aref_end) next_state = ARB_IDLE;
      ARB_WRITE: if (wr_end)   next_state = ARB_IDLE;
      ARB_READ:  if (rd_end)   next_state = ARB_IDLE;
      default:   next_state = ARB_INIT;
    endcase
  end

  assign aref_en = (state == ARB_AREF);
  assign wr_en   = (state == ARB_WRITE);
  assign rd_en   = (state == ARB_READ);

  // The pin mux is purely combinational. Command timing therefore comes
  // from each source's own registered outputs.
  always_comb begin
    cmd        = CMD_NOP;
    sdram_ba   = 2'b11;
    sdram_addr = '1;
    unique case (state)
      ARB_INIT: begin
        cmd        = init_cmd;
        sdram_ba   = init_bank;
        sdram_addr = init_addr;
      end
      ARB_AREF: begin
        cmd        = aref_cmd;
        sdram_ba   = aref_bank;
        sdram_addr = aref_addr;
      end
      ARB_WRITE: begin
        cmd        = wr_cmd;
        sdram_ba   = wr_bank;
        sdram_addr = wr_addr;
      end
      ARB_READ: begin
        cmd        = rd_cmd;
        sdram_ba   = rd_bank;
        sdram_addr = rd_addr;
      end
      default: begin
        cmd        = CMD_NOP;
        sdram_ba   = 2'b11;
        sdram_addr = '1;
      end
    endcase
  end

  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd;
  assign sdram_cke    = 1'b1;
  assign sdram_dq_out = wr_data;
  assign sdram_dq_oe  = (state == ARB_WRITE) && wr_sdram_en;
  assign arb_state    = state;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter. It covers reset
// pass-through, refresh priority, write pin muxing, stray end pulses,
// write/read grant order, and reset in the middle of a write.
module tb_sdram_arbiter;
  import sdram_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 13;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [3:0]        init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [1:0]        init_bank, aref_bank, wr_bank, rd_bank;
  logic [ADDR_W-1:0] init_addr, aref_addr, wr_addr, rd_addr;
  logic              init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end;
  logic [DATA_W-1:0] wr_data;
  logic              wr_sdram_en;
  logic              aref_en, wr_en, rd_en;
  logic              sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]        sdram_ba;
  logic [ADDR_W-1:0] sdram_addr;
  logic [DATA_W-1:0] sdram_dq_out;
  logic              sdram_dq_oe;
  arb_state_e        arb_state;
  logic [3:0]        cmd_pins;

  int total = 0;
  int bad = 0;
  logic [1:0] exp_q[$];  // expected grant order, {wr_en, rd_en}

  // clock / reset
  always #5 clk = ~clk;

  sdram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .init_cmd     (init_cmd),
    .init_bank    (init_bank),
    .init_addr    (init_addr),
    .init_end     (init_end),
    .aref_req     (aref_req),
    .aref_end     (aref_end),
    .aref_cmd     (aref_cmd),
    .aref_bank    (aref_bank),
    .aref_addr    (aref_addr),
    .aref_en      (aref_en),
    .wr_req       (wr_req),
    .wr_end       (wr_end),
    .wr_cmd       (wr_cmd),
    .wr_bank      (wr_bank),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_sdram_en  (wr_sdram_en),
    .wr_en        (wr_en),
    .rd_req       (rd_req),
    .rd_end       (rd_end),
    .rd_cmd       (rd_cmd),
    .rd_bank      (rd_bank),
    .rd_addr      (rd_addr),
    .rd_en        (rd_en),
    .sdram_cke    (sdram_cke),
    .sdram_cs_n   (sdram_cs_n),
    .sdram_ras_n  (sdram_ras_n),
    .sdram_cas_n  (sdram_cas_n),
    .sdram_we_n   (sdram_we_n),
    .sdram_ba     (sdram_ba),
    .sdram_addr   (sdram_addr),
    .sdram_dq_out (sdram_dq_out),
    .sdram_dq_oe  (sdram_dq_oe),
    .arb_state    (arb_state)
  );

  assign cmd_pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n clocks; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) for a write or read grant and check it against the queue.
  // Then finish the operation with the matching *_end pulse and check the idle gap.
  task automatic serve_one();
    int waited;
    logic [1:0] g, e;
    waited = 0;
    while (!wr_en && !rd_en && waited < 8) begin
      step(1);
      waited++;
    end
    g = {wr_en, rd_en};
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 2'b00;
    chk("grant_order", 32'(g), 32'(e));
    if (g == 2'b01) begin
      chk("rd_cmd_pins", 32'(cmd_pins), 32'h5);
      chk("rd_ba", 32'(sdram_ba), 32'h3);
      chk("rd_oe", 32'(sdram_dq_oe), 32'h0);
    end
    step(1);
    chk("grant_held", 32'({wr_en, rd_en}), 32'(e));
    if (g[1]) wr_end = 1'b1;
    else if (g[0]) rd_end = 1'b1;
    step(1);
    wr_end = 1'b0;
    rd_end = 1'b0;
    #1;
    chk("op_gap", 32'({aref_en, wr_en, rd_en}), 32'h0);
    chk("op_gap_cmd", 32'(cmd_pins), 32'h7);
  endtask

  initial begin
    init_cmd = CMD_NOP;   init_bank = 2'd0; init_addr = '0; init_end = 1'b0;
    aref_cmd = CMD_AREF;  aref_bank = 2'd1; aref_addr = 13'h400;
    wr_cmd   = CMD_WRITE; wr_bank   = 2'd2; wr_addr   = 13'h123; wr_data = 16'hA5A5;
    rd_cmd   = CMD_READ;  rd_bank   = 2'd3; rd_addr   = 13'h0F0;
    aref_req = 1'b0; aref_end = 1'b0; wr_req = 1'b0; wr_end = 1'b0;
    rd_req = 1'b0; rd_end = 1'b0; wr_sdram_en = 1'b1;

    // reset values
    #12;
    chk("rst_cmd", 32'(cmd_pins), 32'h7);
    chk("rst_cke", 32'(sdram_cke), 32'h1);
    chk("rst_oe", 32'(sdram_dq_oe), 32'h0);
    chk("rst_grants", 32'({aref_en, wr_en, rd_en}), 32'h0);
    chk("rst_state", 32'(arb_state), 32'(ARB_INIT));

    // init pass-through while a write is already requested
    init_cmd = CMD_PREC; init_addr = 13'h400; wr_req = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    step(3);
    chk("init_cmd", 32'(cmd_pins), 32'h2);
    chk("init_addr", 32'(sdram_addr), 32'h400);
    chk("init_no_wr", 32'(wr_en), 32'h0);
    chk("init_oe", 32'(sdram_dq_oe), 32'h0);
    chk("init_state", 32'(arb_state), 32'(ARB_INIT));

    // init done -> idle NOP pins
    wr_req = 1'b0; init_end = 1'b1;
    step(1);
    chk("idle_state", 32'(arb_state), 32'(ARB_IDLE));
    chk("idle_cmd", 32'(cmd_pins), 32'h7);
    chk("idle_ba", 32'(sdram_ba), 32'h3);
    chk("idle_addr", 32'(sdram_addr), 32'h1FFF);

    // refresh beats a write raised in the same cycle
    aref_req = 1'b1; wr_req = 1'b1;
    step(1);
    chk("aref_grant", 32'({aref_en, wr_en, rd_en}), 32'h4);
    chk("aref_cmd", 32'(cmd_pins), 32'h1);
    chk("aref_ba", 32'(sdram_ba), 32'h1);
    chk("aref_addr", 32'(sdram_addr), 32'h400);
    aref_req = 1'b0; init_end = 1'b0;
    step(2);
    chk("aref_hold", 32'({aref_en, wr_en, rd_en}), 32'h4);
    aref_end = 1'b1;
    step(1);
    aref_end = 1'b0;
    #1;
    chk("aref_done_gap", 32'({aref_en, wr_en, rd_en}), 32'h0);
    chk("aref_done_cmd", 32'(cmd_pins), 32'h7);
    step(1);

    // write pins
    chk("wr_after_aref", 32'({aref_en, wr_en, rd_en}), 32'h2);
    chk("wr_cmd", 32'(cmd_pins), 32'h4);
    chk("wr_ba", 32'(sdram_ba), 32'h2);
    chk("wr_addr", 32'(sdram_addr), 32'h123);
    chk("wr_dq", 32'(sdram_dq_out), 32'hA5A5);
    chk("wr_oe", 32'(sdram_dq_oe), 32'h1);
    wr_sdram_en = 1'b0;
    #1;
    chk("wr_oe_follow", 32'(sdram_dq_oe), 32'h0);
    wr_sdram_en = 1'b1;
    #1;

    // stray end pulses from non-granted sources
    rd_end = 1'b1; aref_end = 1'b1;
    step(1);
    rd_end = 1'b0; aref_end = 1'b0;
    #1;
    chk("stray_state", 32'(arb_state), 32'(ARB_WRITE));
    chk("stray_grants", 32'({aref_en, wr_en, rd_en}), 32'h2);

    // write done
    wr_req = 1'b0; wr_end = 1'b1;
    step(1);
    wr_end = 1'b0;
    #1;
    chk("wr_done_grant", 32'({aref_en, wr_en, rd_en}), 32'h0);
    chk("wr_done_cmd", 32'(cmd_pins), 32'h7);
    chk("wr_done_oe", 32'(sdram_dq_oe), 32'h0);

    // reset in the middle of a write
    wr_req = 1'b1;
    step(1);
    chk("wr2_grant", 32'({aref_en, wr_en, rd_en}), 32'h2);
    init_cmd = CMD_NOP;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid_grant", 32'({aref_en, wr_en, rd_en}), 32'h0);
    chk("rst_mid_oe", 32'(sdram_dq_oe), 32'h0);
    chk("rst_mid_cmd", 32'(cmd_pins), 32'h7);
    chk("rst_mid_state", 32'(arb_state), 32'(ARB_INIT));
    @(negedge clk);
    rstn = 1'b1;
    step(4);
    chk("no_grant_pre_init", 32'({aref_en, wr_en, rd_en}), 32'h0);
    chk("wait_init_state", 32'(arb_state), 32'(ARB_INIT));

    // write and read held together
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
    exp_q.push_back(2'b10); exp_q.push_back(2'b01);
`else
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
    exp_q.push_back(2'b10); exp_q.push_back(2'b10);
`endif
    rd_req = 1'b1; init_end = 1'b1;
    repeat (4) serve_one();
    wr_req = 1'b0; rd_req = 1'b0;
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
